spi_tx: RTL and testbench



---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_tx.sv | 115 +++++++++++
 tb/tb_spi_tx.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master datapath shifters.
// The default length target is shared by the transmit and receive shifters.
package spi_pkg;

    localparam int SPI_WORD_W = 32;
    localparam int SPI_CNT_W  = 16;

    localparam logic [SPI_CNT_W-1:0] SPI_CNT_TRGT_DEFAULT = 16'h8;

    typedef enum logic [1:0] {
        IDLE,
        TRANSMIT,
        WAIT_FIFO
    } tx_state_e;

endpackage

// File: rtl/spi_tx.sv
// SPI master transmit shifter: pops 32-bit words from the TX FIFO and shifts them
// out MSB-first on one lane (standard) or four lanes (quad), one step per tx_edge.
module spi_tx
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 tx_edge,
    output logic                 tx_done,
    output logic                 sdo0,
    output logic                 sdo1,
    output logic                 sdo2,
    output logic                 sdo3,
    input  logic                 en_quad_in,
    input  logic [SPI_CNT_W-1:0] counter_in,
    input  logic                 counter_in_upd,
    input  logic [SPI_WORD_W-1:0] data,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 clk_en_o
);

    tx_state_e state, state_next;

    logic [SPI_CNT_W-1:0]  counter, counter_next;
    logic [SPI_CNT_W-1:0]  counter_trgt, counter_trgt_next;
    logic [SPI_WORD_W-1:0] sr, sr_next;
    logic                  done;
    logic                  word_end;

    // A target of zero wraps to 16'hFFFF here, so it never ends a transfer early.
    assign done     = tx_edge && (counter == (counter_trgt - SPI_CNT_W'(1)));
    assign word_end = en_quad_in ? (counter[2:0] == 3'd7) : (counter[4:0] == 5'd31);

    assign sdo0 = en_quad_in ? sr[28] : sr[31];
    assign sdo1 = en_quad_in ? sr[29] : 1'b0;
    assign sdo2 = en_quad_in ? sr[30] : 1'b0;
    assign sdo3 = en_quad_in ? sr[31] : 1'b0;

    always_comb begin
        counter_trgt_next = counter_trgt;
        if (counter_in_upd) begin
            counter_trgt_next = en_quad_in ? (counter_in >> 2) : counter_in;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        sr_next      = sr;
        data_ready   = 1'b0;
        clk_en_o     = 1'b0;
        tx_done      = 1'b0;

        case (state)
            IDLE: begin
                if (en && data_valid) begin
                    data_ready = 1'b1;
                    sr_next    = data;
                    state_next = TRANSMIT;
                end
            end

            TRANSMIT: begin
                clk_en_o = 1'b1;
                if (tx_edge) begin
                    counter_next = counter + SPI_CNT_W'(1);
                    sr_next      = en_quad_in ? (sr << 4) : (sr << 1);
                    if (done) begin
                        tx_done      = 1'b1;
                        counter_next = '0;
                        state_next   = IDLE;
                    end else if (word_end) begin
                        if (data_valid) begin
                            data_ready = 1'b1;
                            sr_next    = data;
                        end else begin
                            // Drop the clock request in this very cycle so no edge arrives without data.
                            clk_en_o   = 1'b0;
                            state_next = WAIT_FIFO;
                        end
                    end
                end
            end

            WAIT_FIFO: begin
                if (data_valid) begin
                    data_ready = 1'b1;
                    sr_next    = data;
                    state_next = TRANSMIT;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            counter      <= '0;
            counter_trgt <= SPI_CNT_TRGT_DEFAULT;
            sr           <= '0;
        end else begin
            state        <= state_next;
            counter      <= counter_next;
            counter_trgt <= counter_trgt_next;
            sr           <= sr_next;
        end
    end

endmodule

// File: tb/tb_spi_tx.sv
// Randomized scoreboard bench for spi_tx: the expected lane values per shift edge
// are derived from the word list and bit length, then checked by a negedge monitor.
module tb_spi_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        tx_edge;
    logic        tx_done;
    logic        sdo0, sdo1, sdo2, sdo3;
    logic        en_quad_in;
    logic [15:0] counter_in;
    logic        counter_in_upd;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        clk_en_o;

    always #5 clk = ~clk;

    spi_tx dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .tx_edge        (tx_edge),
        .tx_done        (tx_done),
        .sdo0           (sdo0),
        .sdo1           (sdo1),
        .sdo2           (sdo2),
        .sdo3           (sdo3),
        .en_quad_in     (en_quad_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .clk_en_o       (clk_en_o)
    );

    typedef struct {
        logic [3:0] lanes;
        bit         last;
        bit         wend;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] words[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pops     = 0;
    int edges    = 0;
    int low_cnt  = 0;
    bit active   = 1'b0;

    int cur_stall   = 0;
    int stall_start = 0;
    int cur_epw     = 32;
    int cur_nwords  = 0;
    bit cur_rgate   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every shift edge consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1) begin
            if (tx_edge === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_edge: got a shift edge, expected none pending (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("sdo_lanes", {28'd0, sdo3, sdo2, sdo1, sdo0}, {28'd0, e.lanes});
                    check("tx_done", tx_done, e.last);
                    check("data_ready_at_edge", data_ready, e.wend && data_valid);
                    check("clk_en_at_edge", clk_en_o, !(e.wend && !data_valid));
                end
            end else begin
                check("tx_done_quiet", tx_done, 1'b0);
            end
        end
    end

    task automatic step();
        bit pop;
        @(negedge clk);
        pop = (data_ready === 1'b1);
        if (active && clk_en_o !== 1'b1) low_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        tx_edge        = 1'b0;
        counter_in_upd = 1'b0;
        if (pop) begin
            if (fifo_q.size() > 0) fifo_q.delete(0);
            pops++;
            en = 1'b0;
            if (pops == 1) active = 1'b1;
        end
    endtask

    // FIFO pacing: optional stall before the second word, optional random gaps.
    task automatic drive_fifo();
        bit avail;
        avail = (fifo_q.size() > 0);
        if (cur_stall > 0 && pops == 1 && cur_nwords > 1)
            avail = avail && (edges >= cur_epw) && (cyc - stall_start >= cur_stall);
        if (cur_rgate && $urandom_range(0, 3) == 0) avail = 1'b0;
        data_valid = avail;
        data       = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic apply_stimulus(input bit quad, input bit do_load, input int load_val,
                                  input int eff_bits, input int stall, input bit rgate,
                                  input int mid_edge, input int mid_val, input int abort_at);
        int          n_edges;
        int          step_bits;
        int          limit;
        int          b;
        bit          mid_done;
        logic [31:0] w;
        exp_t        e;

        step_bits   = quad ? 4 : 1;
        n_edges     = eff_bits / step_bits;
        cur_epw     = 32 / step_bits;
        cur_nwords  = (eff_bits + 31) / 32;
        cur_stall   = stall;
        cur_rgate   = rgate;
        pops        = 0;
        edges       = 0;
        low_cnt     = 0;
        active      = 1'b0;
        mid_done    = 1'b0;
        stall_start = 0;
        en_quad_in  = quad;

        if (do_load) begin
            counter_in     = 16'(load_val);
            counter_in_upd = 1'b1;
            step();
        end

        for (int k = 0; k < n_edges; k++) begin
            b       = k * step_bits;
            w       = words[b / 32];
            e.lanes = quad ? w[31 - (b % 32) -: 4] : {3'b000, w[31 - (b % 32)]};
            e.last  = (k == n_edges - 1);
            e.wend  = (((k + 1) % cur_epw) == 0) && (k != n_edges - 1);
            exp_q.push_back(e);
        end
        for (int i = 0; i < cur_nwords; i++) fifo_q.push_back(words[i]);
        fifo_q.push_back($urandom());

        en = 1'b1;
        drive_fifo();
        limit = cyc + 8 * n_edges + 200 + stall;
        while (edges < n_edges && cyc < limit) begin
            step();
            if (abort_at > 0 && edges == abort_at) break;
            if (cyc % 4 == 0 && clk_en_o === 1'b1) begin
                tx_edge = 1'b1;
                edges++;
                if (edges == cur_epw) stall_start = cyc;
            end
            if (!tx_edge && mid_edge > 0 && !mid_done && edges >= mid_edge) begin
                counter_in     = 16'(mid_val);
                counter_in_upd = 1'b1;
                mid_done       = 1'b1;
            end
            drive_fifo();
        end

        if (abort_at > 0) begin
            check("abort_edge_reached", edges, abort_at);
            return;
        end
        check("edge_budget", edges, n_edges);
        step();
        active = 1'b0;
        repeat (6) begin
            drive_fifo();
            step();
        end
        check_output(rgate, stall);
    endtask

    task automatic check_output(input bit rgate, input int stall);
        check("pop_count", pops, cur_nwords);
        check("scoreboard_drained", exp_q.size(), 0);
        check("idle_clk_en", clk_en_o, 1'b0);
        if (!rgate && stall == 0) check("clk_en_gaps", low_cnt, 0);
        fifo_q.delete();
        data_valid = 1'b0;
        en         = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit q;
        int bits;
        int stl;

        rstn = 1'b0; en = 1'b0; tx_edge = 1'b0; en_quad_in = 1'b0;
        counter_in = 16'h0; counter_in_upd = 1'b0; data = 32'h0; data_valid = 1'b0;

        repeat (3) step();
        rstn = 1'b1;
        check("reset_sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, 32'h0);
        check("reset_clk_en", clk_en_o, 1'b0);
        check("reset_data_ready", data_ready, 1'b0);
        check("reset_tx_done", tx_done, 1'b0);

        en = 1'b1;
        repeat (4) step();
        check("en_no_valid_clk_en", clk_en_o, 1'b0);
        check("en_no_valid_ready", data_ready, 1'b0);
        en = 1'b0;

        $display("[TB] standard 8-bit transfer");
        words = '{32'hA5000000};
        apply_stimulus(1'b0, 1'b1, 8, 8, 0, 1'b0, 0, 0, 0);

        $display("[TB] quad 64-bit transfer, continuous data");
        words = '{32'h12345678, 32'h9ABCDEF0};
        apply_stimulus(1'b1, 1'b1, 64, 64, 0, 1'b0, 0, 0, 0);

        $display("[TB] standard 64-bit transfer, FIFO dry at word boundary");
        words = '{$urandom(), $urandom()};
        apply_stimulus(1'b0, 1'b1, 64, 64, 10, 1'b0, 0, 0, 0);

        $display("[TB] quad 32-bit transfer, done coincides with word end");
        words = '{$urandom()};
        apply_stimulus(1'b1, 1'b1, 32, 32, 0, 1'b0, 0, 0, 0);

        $display("[TB] reset in the middle of a transfer");
        words = '{32'hFFFFFFFF};
        apply_stimulus(1'b0, 1'b1, 32, 32, 0, 1'b0, 0, 0, 5);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("midreset_sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, 32'h0);
        check("midreset_clk_en", clk_en_o, 1'b0);
        check("midreset_data_ready", data_ready, 1'b0);
        check("midreset_tx_done", tx_done, 1'b0);
        exp_q.delete();
        fifo_q.delete();
        data_valid = 1'b0;
        en = 1'b0;
        words = '{$urandom()};
        apply_stimulus(1'b0, 1'b0, 0, 8, 0, 1'b0, 0, 0, 0);

        $display("[TB] zero target, retargeted to 40 mid-transfer");
        words = '{$urandom(), $urandom()};
        apply_stimulus(1'b0, 1'b1, 0, 40, 0, 1'b0, 20, 40, 0);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 12; t++) begin
            q    = 1'($urandom_range(0, 1));
            bits = q ? 4 * $urandom_range(1, 24) : $urandom_range(1, 96);
            stl  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 8);
            words.delete();
            repeat (3) words.push_back($urandom());
            apply_stimulus(q, 1'b1, bits, bits, stl, 1'b1, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
